// File: rtl/dm_axi_master_if.sv
// AXI4 channel bundle between the MEM-stage master and its memory slave.
// Single-beat only; ID fields carried for protocol completeness.
interface dm_axi_master_if #(
  parameter int ID_W = 4
);
  logic [ID_W-1:0] AWID;
  logic [31:0]     AWADDR;
  logic [7:0]      AWLEN;
  logic [2:0]      AWSIZE;
  logic [1:0]      AWBURST;
  logic            AWVALID;
  logic            AWREADY;

  logic [31:0]     WDATA;
  logic [3:0]      WSTRB;
  logic            WLAST;
  logic            WVALID;
  logic            WREADY;

  logic [ID_W-1:0] BID;
  logic [1:0]      BRESP;
  logic            BVALID;
  logic            BREADY;

  logic [ID_W-1:0] ARID;
  logic [31:0]     ARADDR;
  logic [7:0]      ARLEN;
  logic [2:0]      ARSIZE;
  logic [1:0]      ARBURST;
  logic            ARVALID;
  logic            ARREADY;

  logic [ID_W-1:0] RID;
  logic [31:0]     RDATA;
  logic [1:0]      RRESP;
  logic            RLAST;
  logic            RVALID;
  logic            RREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, input AWREADY,
    output WDATA, WSTRB, WLAST, WVALID, input WREADY,
    input  BID, BRESP, BVALID, output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, input ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID, output RREADY
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID, output WREADY,
    output BID, BRESP, BVALID, input BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID, input RREADY
  );
endinterface

// File: rtl/dm_axi_master.sv
// MEM-stage AXI4 master: turns load/store requests into single-beat AXI
// transactions, one outstanding, with completion status held until advance_i.
//
// state        | meaning
// IDLE         | no transaction; accept request, clear status on advance_i
// RD_ADDR      | ARVALID high, waiting for ARREADY
// RD_DATA      | RREADY high, waiting for RVALID && RLAST
// WR_ADDR_DATA | AWVALID/WVALID high until each handshakes
// WR_RESP      | BREADY high, waiting for BVALID
module dm_axi_master #(
  parameter int              ID_W   = 4,
  parameter logic [ID_W-1:0] MST_ID = 4'd1
) (
  input  logic                   ACLK,
  input  logic                   ARESETn,
  input  logic                   mem_read_i,
  input  logic                   mem_write_i,
  input  logic [31:0]            mem_addr_i,
  input  logic [31:0]            mem_wdata_i,
  input  logic [3:0]             mem_web_i,
  input  logic                   advance_i,
  dm_axi_master_if.master        axi,
  output logic                   rvalid_o,
  output logic [31:0]            raddr_o,
  output logic [31:0]            rdata_o,
  output logic                   wvalid_o,
  output logic [31:0]            waddr_o,
  output logic [31:0]            wdata_o,
  output logic [3:0]             web_o,
  output logic                   err_o
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_ADDR_DATA, WR_RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [31:0] req_wdata_q, req_wdata_d;
  logic [3:0]  req_web_q, req_web_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] raddr_q, raddr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        wvalid_q, wvalid_d;
  logic [31:0] waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  web_q, web_d;
  logic        err_q, err_d;

  logic rd_done, wr_done;
  logic unused_ids;

  // A held request that already completed must not be re-issued.
  assign rd_done = rvalid_q && (raddr_q == mem_addr_i);
  assign wr_done = wvalid_q && (waddr_q == mem_addr_i) &&
                   (wdata_q == mem_wdata_i) && (web_q == mem_web_i);

  assign unused_ids = ^{axi.BID, axi.RID};

  assign axi.AWID    = MST_ID;
  assign axi.AWADDR  = req_addr_q;
  assign axi.AWLEN   = 8'd0;
  assign axi.AWSIZE  = 3'b010;
  assign axi.AWBURST = 2'b01;
  assign axi.AWVALID = (state_q == WR_ADDR_DATA) && !aw_done_q;
  assign axi.WDATA   = req_wdata_q;
  assign axi.WSTRB   = ~req_web_q;
  assign axi.WLAST   = 1'b1;
  assign axi.WVALID  = (state_q == WR_ADDR_DATA) && !w_done_q;
  assign axi.BREADY  = (state_q == WR_RESP);
  assign axi.ARID    = MST_ID;
  assign axi.ARADDR  = req_addr_q;
  assign axi.ARLEN   = 8'd0;
  assign axi.ARSIZE  = 3'b010;
  assign axi.ARBURST = 2'b01;
  assign axi.ARVALID = (state_q == RD_ADDR);
  assign axi.RREADY  = (state_q == RD_DATA);

  always_comb begin
    state_d     = state_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_web_d   = req_web_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    rvalid_d    = rvalid_q;
    raddr_d     = raddr_q;
    rdata_d     = rdata_q;
    wvalid_d    = wvalid_q;
    waddr_d     = waddr_q;
    wdata_d     = wdata_q;
    web_d       = web_q;
    err_d       = err_q;
    unique case (state_q)
      IDLE: begin
        if (advance_i) begin
          rvalid_d = 1'b0;
          wvalid_d = 1'b0;
        end
        if (mem_write_i && !wr_done) begin
          req_addr_d  = mem_addr_i;
          req_wdata_d = mem_wdata_i;
          req_web_d   = mem_web_i;
          aw_done_d   = 1'b0;
          w_done_d    = 1'b0;
          state_d     = WR_ADDR_DATA;
        end else if (mem_read_i && !rd_done) begin
          req_addr_d = mem_addr_i;
          state_d    = RD_ADDR;
        end
      end
      WR_ADDR_DATA: begin
        aw_done_d = aw_done_q || (axi.AWVALID && axi.AWREADY);
        w_done_d  = w_done_q  || (axi.WVALID && axi.WREADY);
        if (aw_done_d && w_done_d) state_d = WR_RESP;
      end
      WR_RESP: begin
        if (axi.BVALID) begin
          waddr_d  = req_addr_q;
          wdata_d  = req_wdata_q;
          web_d    = req_web_q;
          wvalid_d = 1'b1;
          err_d    = err_q || (axi.BRESP != 2'b00);
          state_d  = IDLE;
        end
      end
      RD_ADDR: begin
        if (axi.ARREADY) state_d = RD_DATA;
      end
      RD_DATA: begin
        if (axi.RVALID && axi.RLAST) begin
          rdata_d  = axi.RDATA;
          raddr_d  = req_addr_q;
          rvalid_d = 1'b1;
          err_d    = err_q || (axi.RRESP != 2'b00);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q     <= IDLE;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_web_q   <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      rvalid_q    <= 1'b0;
      raddr_q     <= '0;
      rdata_q     <= '0;
      wvalid_q    <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      web_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_web_q   <= req_web_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      rvalid_q    <= rvalid_d;
      raddr_q     <= raddr_d;
      rdata_q     <= rdata_d;
      wvalid_q    <= wvalid_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      web_q       <= web_d;
      err_q       <= err_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign raddr_o  = raddr_q;
  assign rdata_o  = rdata_q;
  assign wvalid_o = wvalid_q;
  assign waddr_o  = waddr_q;
  assign wdata_o  = wdata_q;
  assign web_o    = web_q;
  assign err_o    = err_q;

endmodule

// File: tb/tb_dm_axi_master.sv
// Bench for dm_axi_master: delay-configurable AXI slave, transaction-level
// reference model compared every cycle, plus directed literal checks.
module tb_dm_axi_master;

  logic        ACLK = 1'b0;
  logic        ARESETn;
  logic        mem_read_i, mem_write_i, advance_i;
  logic [31:0] mem_addr_i, mem_wdata_i;
  logic [3:0]  mem_web_i;
  logic        rvalid_o, wvalid_o, err_o;
  logic [31:0] raddr_o, rdata_o, waddr_o, wdata_o;
  logic [3:0]  web_o;

  int checks = 0;
  int errors = 0;

  dm_axi_master_if #(.ID_W(4)) axi ();

  dm_axi_master #(.ID_W(4), .MST_ID(4'd1)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i), .mem_web_i(mem_web_i),
    .advance_i(advance_i), .axi(axi),
    .rvalid_o(rvalid_o), .raddr_o(raddr_o), .rdata_o(rdata_o),
    .wvalid_o(wvalid_o), .waddr_o(waddr_o), .wdata_o(wdata_o),
    .web_o(web_o), .err_o(err_o)
  );

  always #5 ACLK = ~ACLK;

  // ---------------- slave ----------------
  int aw_delay = 0, w_delay = 0, ar_delay = 0, r_delay = 0, b_delay = 0;
  int aw_wait, w_wait, ar_wait, r_wait, b_wait;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = 32'hDEAD_BEEF;
  logic aw_got, w_got, b_pend, r_pend;

  assign axi.AWREADY = axi.AWVALID && (aw_wait >= aw_delay);
  assign axi.WREADY  = axi.WVALID  && (w_wait  >= w_delay);
  assign axi.ARREADY = axi.ARVALID && (ar_wait >= ar_delay);
  assign axi.BVALID  = b_pend && (b_wait >= b_delay);
  assign axi.BRESP   = bresp_cfg;
  assign axi.BID     = 4'd1;
  assign axi.RVALID  = r_pend && (r_wait >= r_delay);
  assign axi.RDATA   = rdata_cfg;
  assign axi.RRESP   = rresp_cfg;
  assign axi.RLAST   = 1'b1;
  assign axi.RID     = 4'd1;

  always @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0; r_wait <= 0; b_wait <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
    end else begin
      aw_wait <= (axi.AWVALID && axi.AWREADY) ? 0 : (axi.AWVALID ? aw_wait + 1 : aw_wait);
      w_wait  <= (axi.WVALID && axi.WREADY)   ? 0 : (axi.WVALID  ? w_wait + 1  : w_wait);
      ar_wait <= (axi.ARVALID && axi.ARREADY) ? 0 : (axi.ARVALID ? ar_wait + 1 : ar_wait);
      if ((aw_got || (axi.AWVALID && axi.AWREADY)) && (w_got || (axi.WVALID && axi.WREADY))) begin
        b_pend <= 1'b1; aw_got <= 1'b0; w_got <= 1'b0;
      end else begin
        aw_got <= aw_got || (axi.AWVALID && axi.AWREADY);
        w_got  <= w_got  || (axi.WVALID && axi.WREADY);
      end
      if (axi.BVALID && axi.BREADY) begin b_pend <= 1'b0; b_wait <= 0; end
      else if (b_pend) b_wait <= b_wait + 1;
      if (axi.ARVALID && axi.ARREADY) r_pend <= 1'b1;
      if (axi.RVALID && axi.RREADY) begin r_pend <= 1'b0; r_wait <= 0; end
      else if (r_pend) r_wait <= r_wait + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // One outstanding transaction; completion record held until advance in idle.
  bit m_busy, m_wr, m_ph2, m_awd, m_wd;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_web;
  bit m_rv, m_wv, m_err;
  logic [31:0] m_raddr, m_rdata, m_waddr, m_wdat;
  logic [3:0]  m_webo;
  int aw_hs = 0, ar_hs = 0, aw_hi = 0, w_hi = 0;

  always @(negedge ACLK) begin
    bit e_awv, e_wv, e_br, e_arv, e_rr, wm, rm;
    if (!ARESETn) begin
      m_busy = 0; m_wr = 0; m_ph2 = 0; m_awd = 0; m_wd = 0;
      m_addr = '0; m_wdata = '0; m_web = '0;
      m_rv = 0; m_wv = 0; m_err = 0;
      m_raddr = '0; m_rdata = '0; m_waddr = '0; m_wdat = '0; m_webo = '0;
    end else begin
      e_awv = m_busy && m_wr && !m_ph2 && !m_awd;
      e_wv  = m_busy && m_wr && !m_ph2 && !m_wd;
      e_br  = m_busy && m_wr && m_ph2;
      e_arv = m_busy && !m_wr && !m_ph2;
      e_rr  = m_busy && !m_wr && m_ph2;
      chk("awvalid", axi.AWVALID, e_awv);
      chk("wvalid",  axi.WVALID,  e_wv);
      chk("bready",  axi.BREADY,  e_br);
      chk("arvalid", axi.ARVALID, e_arv);
      chk("rready",  axi.RREADY,  e_rr);
      if (e_awv) begin
        chk("awaddr", axi.AWADDR, m_addr);
        chk("aw_const", {axi.AWID, axi.AWLEN, axi.AWSIZE, axi.AWBURST}, {4'd1, 8'd0, 3'b010, 2'b01});
      end
      if (e_wv) begin
        chk("wdata", axi.WDATA, m_wdata);
        chk("wstrb_wlast", {axi.WSTRB, axi.WLAST}, {~m_web, 1'b1});
      end
      if (e_arv) begin
        chk("araddr", axi.ARADDR, m_addr);
        chk("ar_const", {axi.ARID, axi.ARLEN, axi.ARSIZE, axi.ARBURST}, {4'd1, 8'd0, 3'b010, 2'b01});
      end
      chk("rvalid_o", rvalid_o, m_rv);
      chk("raddr_o", raddr_o, m_raddr);
      chk("rdata_o", rdata_o, m_rdata);
      chk("wvalid_o", wvalid_o, m_wv);
      chk("waddr_o", waddr_o, m_waddr);
      chk("wdata_o", wdata_o, m_wdat);
      chk("web_o", web_o, m_webo);
      chk("err_o", err_o, m_err);

      if (axi.AWVALID) aw_hi++;
      if (axi.WVALID) w_hi++;
      if (axi.AWVALID && axi.AWREADY) aw_hs++;
      if (axi.ARVALID && axi.ARREADY) ar_hs++;

      if (!m_busy) begin
        wm = m_wv && m_waddr == mem_addr_i && m_wdat == mem_wdata_i && m_webo == mem_web_i;
        rm = m_rv && m_raddr == mem_addr_i;
        if (advance_i) begin m_rv = 0; m_wv = 0; end
        if (mem_write_i && !wm) begin
          m_busy = 1; m_wr = 1; m_ph2 = 0; m_awd = 0; m_wd = 0;
          m_addr = mem_addr_i; m_wdata = mem_wdata_i; m_web = mem_web_i;
        end else if (mem_read_i && !rm) begin
          m_busy = 1; m_wr = 0; m_ph2 = 0; m_addr = mem_addr_i;
        end
      end else if (m_wr && !m_ph2) begin
        if (e_awv && axi.AWREADY) m_awd = 1;
        if (e_wv && axi.WREADY) m_wd = 1;
        if (m_awd && m_wd) m_ph2 = 1;
      end else if (m_wr) begin
        if (axi.BVALID) begin
          m_wv = 1; m_waddr = m_addr; m_wdat = m_wdata; m_webo = m_web;
          if (axi.BRESP != 2'b00) m_err = 1;
          m_busy = 0;
        end
      end else if (!m_ph2) begin
        if (axi.ARREADY) m_ph2 = 1;
      end else if (axi.RVALID && axi.RLAST) begin
        m_rv = 1; m_raddr = m_addr; m_rdata = axi.RDATA;
        if (axi.RRESP != 2'b00) m_err = 1;
        m_busy = 0;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge ACLK); #1;
  endtask

  task automatic pulse_advance();
    advance_i = 1'b1; step(); advance_i = 1'b0;
  endtask

  task automatic wait_rd(input logic [31:0] a);
    bit ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      step();
      if (rvalid_o && raddr_o == a) ok = 1;
    end
    chk("rd_complete_in_time", {31'd0, ok}, 32'd1);
  endtask

  task automatic wait_wr(input logic [31:0] a);
    bit ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      step();
      if (wvalid_o && waddr_o == a) ok = 1;
    end
    chk("wr_complete_in_time", {31'd0, ok}, 32'd1);
  endtask

  initial begin
    ARESETn = 1'b0; mem_read_i = 0; mem_write_i = 0; advance_i = 0;
    mem_addr_i = '0; mem_wdata_i = '0; mem_web_i = 4'b1111;
    repeat (3) step();
    chk("reset_status", {29'd0, rvalid_o, wvalid_o, err_o}, 32'd0);
    chk("reset_valids", {30'd0, axi.AWVALID, axi.ARVALID}, 32'd0);
    chk("reset_rdata", rdata_o, 32'd0);

    // read, always-ready slave, request present at reset release
    ARESETn = 1'b1; mem_read_i = 1; mem_addr_i = 32'h0001_0004;
    step();
    chk("rd_arvalid_c1", axi.ARVALID, 1);
    chk("rd_araddr_c1", axi.ARADDR, 32'h0001_0004);
    step();
    chk("rd_not_done_c2", rvalid_o, 0);
    step();
    chk("rd_done_c3", rvalid_o, 1);
    chk("rd_rdata", rdata_o, 32'hDEAD_BEEF);
    chk("rd_raddr", raddr_o, 32'h0001_0004);
    repeat (5) step();
    chk("rd_no_reissue", ar_hs, 1);
    mem_read_i = 0;
    pulse_advance();
    chk("adv_clears_rvalid", rvalid_o, 0);
    chk("adv_keeps_rdata", rdata_o, 32'hDEAD_BEEF);

    // store, AWREADY delayed 3 cycles
    aw_delay = 3; aw_hi = 0; w_hi = 0;
    mem_write_i = 1; mem_addr_i = 32'h40; mem_wdata_i = 32'h1234_5678; mem_web_i = 4'b1100;
    step();
    chk("st_wstrb", axi.WSTRB, 4'b0011);
    chk("st_aw_w_together", {axi.AWVALID, axi.WVALID}, 2'b11);
    wait_wr(32'h40);
    chk("st_aw_hold", aw_hi, 4);
    chk("st_w_hold", w_hi, 1);
    chk("st_web_o", web_o, 4'b1100);
    chk("st_wdata_o", wdata_o, 32'h1234_5678);
    mem_write_i = 0; aw_delay = 0;
    pulse_advance();

    // held identical store: one transaction, a second only after advance
    aw_hs = 0;
    mem_write_i = 1; mem_addr_i = 32'h20; mem_wdata_i = 32'hA5A5_0001; mem_web_i = 4'b0000;
    repeat (10) step();
    chk("st_once", aw_hs, 1);
    chk("st_held_wvalid", wvalid_o, 1);
    pulse_advance();
    repeat (10) step();
    chk("st_twice", aw_hs, 2);

    // read and write together: write first, then the read
    advance_i = 1; mem_read_i = 1;
    mem_addr_i = 32'h24; mem_wdata_i = 32'h0BAD_F00D; mem_web_i = 4'b0101;
    step(); advance_i = 0;
    chk("prio_write_first", {axi.AWVALID, axi.ARVALID}, 2'b10);
    wait_wr(32'h24);
    wait_rd(32'h24);
    chk("prio_read_after", rdata_o, 32'hDEAD_BEEF);
    mem_read_i = 0; mem_write_i = 0;
    pulse_advance();

    // SLVERR on B: completes, err sticky
    bresp_cfg = 2'b10;
    mem_write_i = 1; mem_addr_i = 32'h30; mem_wdata_i = 32'hCAFE_0030; mem_web_i = 4'b0000;
    wait_wr(32'h30);
    chk("bresp_err_set", err_o, 1);
    mem_write_i = 0; bresp_cfg = 2'b00;
    pulse_advance();
    mem_write_i = 1; mem_addr_i = 32'h34;
    wait_wr(32'h34);
    chk("err_sticky", err_o, 1);
    mem_write_i = 0;
    pulse_advance();

    // ARADDR stable while address input moves
    ar_delay = 4; rdata_cfg = 32'h5555_AAAA;
    mem_read_i = 1; mem_addr_i = 32'h100;
    step();
    chk("ar_stall_valid", axi.ARVALID, 1);
    mem_addr_i = 32'h200;
    step();
    chk("ar_stable_1", axi.ARADDR, 32'h100);
    step();
    chk("ar_stable_2", axi.ARADDR, 32'h100);
    wait_rd(32'h100);
    chk("ar_stall_rdata", rdata_o, 32'h5555_AAAA);
    wait_rd(32'h200);
    mem_read_i = 0; ar_delay = 0;
    pulse_advance();

    // reset in RD_DATA before RVALID
    r_delay = 5;
    mem_read_i = 1; mem_addr_i = 32'h300;
    begin
      bit seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        step();
        if (axi.RREADY) seen = 1;
      end
      chk("rst_reached_rd_data", {31'd0, seen}, 32'd1);
    end
    ARESETn = 1'b0;
    #1;
    chk("rst_now_rready", axi.RREADY, 0);
    chk("rst_now_status", {29'd0, rvalid_o, wvalid_o, err_o}, 32'd0);
    chk("rst_now_raddr", raddr_o, 32'd0);
    chk("rst_now_rdata", rdata_o, 32'd0);
    chk("rst_now_waddr", waddr_o, 32'd0);
    step(); step();
    ar_hs = 0; r_delay = 0; rdata_cfg = 32'h0304_0304;
    mem_addr_i = 32'h304; ARESETn = 1'b1;
    step();
    chk("rst_fresh_ar", axi.ARVALID, 1);
    chk("rst_fresh_araddr", axi.ARADDR, 32'h304);
    wait_rd(32'h304);
    chk("rst_fresh_ar_count", ar_hs, 1);
    chk("rst_fresh_rdata", rdata_o, 32'h0304_0304);
    mem_read_i = 0;
    repeat (3) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, errors so far %0d", errors);
    $fatal(1, "watchdog expired");
  end

endmodule
